// File: rtl/winograd_accum_ctrl.sv
// Accumulation and write-back sequencer for Winograd output tiles: counts input-depth
// beats per block pair, then drains the up-to-four finished tiles (2 blocks x 2 od lanes).
module winograd_accum_ctrl #(
    parameter int ADDR_W = 16,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_wen_i,
    input  logic [ID_W-1:0]   total_id_i,
    input  logic [7:0]        total_od_i,
    input  logic [7:0]        block_cnt_i,
    input  logic              start_i,
    input  logic [7:0]        od_base_i,
    input  logic              pe_valid_i,
    output logic              pe_ready_o,
    output logic              acc_en_o,
    output logic              acc_first_o,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [ADDR_W-1:0] wb_addr_o,
    output logic [1:0]        wb_sel_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {IDLE, ACCUM, WRITE, DONE} state_t;

    state_t state, state_nxt;

    logic [ID_W-1:0] cfg_id;
    logic [7:0]      cfg_od;
    logic [7:0]      cfg_blk;
    logic [7:0]      od_base;
    logic [7:0]      block_idx;
    logic [ID_W-1:0] id_cnt;

    logic [ID_W-1:0]   eff_id;
    logic [7:0]        eff_blk;
    logic              beat;
    logic              last_beat;
    logic              blk_lane_ok;
    logic              od_lane_ok;
    logic              last_pair;
    logic              handshake;
    logic              sel_found;
    logic [1:0]        sel_nxt;
    logic [1:0]        addr_sel;
    logic [ADDR_W-1:0] od_term;
    logic [ADDR_W-1:0] addr_calc;

    // A zero count from software means "one", so the sequencer never spins forever.
    assign eff_id      = (cfg_id == '0) ? ID_W'(1) : cfg_id;
    assign eff_blk     = (cfg_blk == 8'd0) ? 8'd1 : cfg_blk;
    assign beat        = pe_valid_i && (state == ACCUM);
    assign last_beat   = beat && (id_cnt == eff_id - ID_W'(1));
    assign blk_lane_ok = ({1'b0, block_idx} + 9'd1) < {1'b0, eff_blk};
    assign od_lane_ok  = ({1'b0, od_base} + 9'd1) < {1'b0, cfg_od};
    assign last_pair   = ({1'b0, block_idx} + 9'd2) >= {1'b0, eff_blk};
    assign handshake   = wb_valid_o && wb_ready_i;

    // Next tile to write after the current one; lanes beyond the map edge are skipped.
    always_comb begin
        sel_found = 1'b0;
        sel_nxt   = wb_sel_o;
        for (int k = 3; k >= 1; k--) begin
            if ((2'(k) > wb_sel_o) && (blk_lane_ok || !k[0]) && (od_lane_ok || !k[1])) begin
                sel_nxt   = 2'(k);
                sel_found = 1'b1;
            end
        end
    end

    assign addr_sel  = (state == WRITE) ? sel_nxt : 2'd0;
    assign od_term   = ADDR_W'(od_base) + ADDR_W'(addr_sel[1]);
    assign addr_calc = od_term * ADDR_W'(eff_blk) + ADDR_W'(block_idx) + ADDR_W'(addr_sel[0]);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every output is defaulted first so no path through the case infers a latch.
    always_comb begin
        state_nxt   = state;
        pe_ready_o  = 1'b0;
        acc_en_o    = 1'b0;
        acc_first_o = 1'b0;
        busy_o      = (state != IDLE);
        done_o      = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) state_nxt = ACCUM;
            end
            ACCUM: begin
                pe_ready_o  = 1'b1;
                acc_en_o    = pe_valid_i;
                acc_first_o = pe_valid_i && (id_cnt == '0);
                if (last_beat) state_nxt = WRITE;
            end
            WRITE: begin
                if (handshake && !sel_found) state_nxt = last_pair ? DONE : ACCUM;
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_id     <= '0;
            cfg_od     <= 8'd0;
            cfg_blk    <= 8'd0;
            od_base    <= 8'd0;
            block_idx  <= 8'd0;
            id_cnt     <= '0;
            wb_valid_o <= 1'b0;
            wb_addr_o  <= '0;
            wb_sel_o   <= 2'd0;
        end else begin
            if (state == IDLE) begin
                if (cfg_wen_i) begin
                    cfg_id  <= total_id_i;
                    cfg_od  <= total_od_i;
                    cfg_blk <= block_cnt_i;
                end
                if (start_i) begin
                    od_base   <= od_base_i;
                    block_idx <= 8'd0;
                    id_cnt    <= '0;
                end
            end
            if (beat) id_cnt <= last_beat ? '0 : id_cnt + ID_W'(1);
            if (last_beat) begin
                wb_valid_o <= 1'b1;
                wb_sel_o   <= 2'd0;
                wb_addr_o  <= addr_calc;
            end
            if ((state == WRITE) && handshake) begin
                if (sel_found) begin
                    wb_sel_o  <= sel_nxt;
                    wb_addr_o <= addr_calc;
                end else begin
                    wb_valid_o <= 1'b0;
                    if (!last_pair) block_idx <= block_idx + 8'd2;
                end
            end
        end
    end

endmodule

// File: tb/tb_winograd_accum_ctrl.sv
// Randomized bench for winograd_accum_ctrl: an ordered list of expected beats and
// writes, derived from the configuration, is consumed as the DUT handshakes.
module tb_winograd_accum_ctrl;

    localparam int ADDR_W = 16;
    localparam int ID_W   = 4;
    localparam int BUDGET = 5000;

    typedef struct {
        bit          is_beat;
        bit          first;
        logic [15:0] addr;
        logic [1:0]  sel;
    } item_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_wen_i;
    logic [ID_W-1:0]   total_id_i;
    logic [7:0]        total_od_i;
    logic [7:0]        block_cnt_i;
    logic              start_i;
    logic [7:0]        od_base_i;
    logic              pe_valid_i;
    logic              pe_ready_o;
    logic              acc_en_o;
    logic              acc_first_o;
    logic              wb_valid_o;
    logic              wb_ready_i;
    logic [ADDR_W-1:0] wb_addr_o;
    logic [1:0]        wb_sel_o;
    logic              busy_o;
    logic              done_o;

    int    n_checks = 0;
    int    n_fail   = 0;
    item_t exp_q[$];

    winograd_accum_ctrl #(.ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
        .clk(clk), .reset(reset), .cfg_wen_i(cfg_wen_i), .total_id_i(total_id_i),
        .total_od_i(total_od_i), .block_cnt_i(block_cnt_i), .start_i(start_i),
        .od_base_i(od_base_i), .pe_valid_i(pe_valid_i), .pe_ready_o(pe_ready_o),
        .acc_en_o(acc_en_o), .acc_first_o(acc_first_o), .wb_valid_o(wb_valid_o),
        .wb_ready_i(wb_ready_i), .wb_addr_o(wb_addr_o), .wb_sel_o(wb_sel_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected order: id beats per block pair, then that pair's surviving tiles.
    task automatic build_model(input int id, input int od, input int blk, input int base);
        int    eid;
        int    eb;
        item_t it;
        eid = (id == 0) ? 1 : id;
        eb  = (blk == 0) ? 1 : blk;
        exp_q.delete();
        for (int b = 0; b < eb; b += 2) begin
            for (int k = 0; k < eid; k++) begin
                it = '{is_beat: 1'b1, first: (k == 0), addr: 16'd0, sel: 2'd0};
                exp_q.push_back(it);
            end
            for (int s = 0; s < 4; s++) begin
                if ((s % 2 == 1) && (b + 1 >= eb)) continue;
                if ((s / 2 == 1) && (base + 1 >= od)) continue;
                it = '{is_beat: 1'b0, first: 1'b0,
                       addr: 16'((base + s / 2) * eb + b + s % 2), sel: 2'(s)};
                exp_q.push_back(it);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pe_ready"}, pe_ready_o, 0);
        check({tag, "_acc_en"}, acc_en_o, 0);
        check({tag, "_wb_valid"}, wb_valid_o, 0);
        check({tag, "_wb_addr"}, wb_addr_o, 0);
        check({tag, "_wb_sel"}, wb_sel_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
    endtask

    task automatic run_pair(input int id, input int od, input int blk, input int base,
                            input bit full, input bit stall, input bit noise, input bit rst_in_write);
        item_t it;
        bit    finished = 1'b0;
        bit    aborted  = 1'b0;
        int    stall_left;
        stall_left = stall ? 5 : 0;

        @(negedge clk);
        cfg_wen_i   = 1'b1;
        total_id_i  = ID_W'(id);
        total_od_i  = 8'(od);
        block_cnt_i = 8'(blk);
        @(negedge clk);
        cfg_wen_i = 1'b0;
        start_i   = 1'b1;
        od_base_i = 8'(base);
        build_model(id, od, blk, base);

        for (int cyc = 0; cyc < BUDGET && !finished; cyc++) begin
            @(negedge clk);
            start_i    = 1'b0;
            cfg_wen_i  = 1'b0;
            pe_valid_i = full ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (exp_q.size() > 0 && !exp_q[0].is_beat && stall_left > 0) begin
                wb_ready_i = 1'b0;
                stall_left--;
            end else begin
                wb_ready_i = full ? 1'b1 : ($urandom_range(0, 3) != 0);
            end
            if (noise) begin
                cfg_wen_i   = 1'($urandom_range(0, 1));
                start_i     = 1'($urandom_range(0, 1));
                total_id_i  = ID_W'($urandom);
                total_od_i  = 8'($urandom);
                block_cnt_i = 8'($urandom);
                od_base_i   = 8'($urandom);
            end
            #1;
            if (exp_q.size() == 0) begin
                check("done_pulse", done_o, 1);
                check("done_busy", busy_o, 1);
                check("done_wb_valid", wb_valid_o, 0);
                check("done_pe_ready", pe_ready_o, 0);
                finished = 1'b1;
            end else begin
                it = exp_q[0];
                check("done_early", done_o, 0);
                check("busy", busy_o, 1);
                check("pe_ready", pe_ready_o, it.is_beat);
                check("wb_valid", wb_valid_o, !it.is_beat);
                check("acc_en", acc_en_o, pe_valid_i && it.is_beat);
                if (it.is_beat) begin
                    if (pe_valid_i) begin
                        check("acc_first", acc_first_o, it.first);
                        void'(exp_q.pop_front());
                    end
                end else begin
                    check("wb_addr", wb_addr_o, it.addr);
                    check("wb_sel", wb_sel_o, it.sel);
                    if (rst_in_write) begin
                        reset = 1'b1;
                        #1;
                        check_reset_outputs("rst_mid");
                        aborted  = 1'b1;
                        finished = 1'b1;
                    end else if (wb_ready_i) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end

        if (!finished) begin
            check("timeout", 0, 1);
            reset = 1'b1;
        end
        @(negedge clk);
        reset      = 1'b0;
        start_i    = 1'b0;
        cfg_wen_i  = 1'b0;
        pe_valid_i = 1'b0;
        #1;
        check("idle_busy", busy_o, 0);
        check("idle_done", done_o, 0);
    endtask

    initial begin
        reset       = 1'b1;
        cfg_wen_i   = 1'b0;
        total_id_i  = '0;
        total_od_i  = 8'd0;
        block_cnt_i = 8'd0;
        start_i     = 1'b0;
        od_base_i   = 8'd0;
        pe_valid_i  = 1'b1;
        wb_ready_i  = 1'b1;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        // Canonical 4-block sequence with the PE array and buffer always ready.
        run_pair(3, 4, 4, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        // Odd block count and odd od count.
        run_pair(1, 2, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_pair(1, 3, 2, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        // Output-buffer backpressure and ignored start/config while busy.
        run_pair(2, 4, 2, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_pair(2, 4, 4, 2, 1'b0, 1'b0, 1'b1, 1'b0);
        // Reset in the middle of a write, then fresh sequences with zero counts.
        run_pair(2, 4, 4, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_pair(0, 1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_pair(0, 2, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);

        for (int n = 0; n < 20; n++) begin
            run_pair($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 20),
                     $urandom_range(0, 255), 1'b0, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
